// File: rtl/csa_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined carry-select adder/subtractor.
// The slave side is the adder; the master side is whoever feeds operands and drains results.
interface csa_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_addsub.sv
// Three-stage carry-select adder/subtractor: operand capture, dual-hypothesis block sums,
// then a carry-select mux chain. The whole pipeline freezes while a result waits downstream.
module csa_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic             clk,
  input logic             rst_n,
  csa_pipe_addsub_if.slave bus
);
  localparam int NBLK = WIDTH / BLOCK;

  if (WIDTH < 2 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
    $error("csa_pipe_addsub: WIDTH must be >= 2 and an exact multiple of BLOCK");
  end

  logic                        stall_s;
  logic                        adv_s;
  logic                        v1_r, v2_r, v3_r;
  logic [WIDTH-1:0]            a1_r, bx1_r;
  logic                        c01_r;
  logic [NBLK-1:0][BLOCK:0]    blk0_s, blk1_s;
  logic [NBLK-1:0][BLOCK-1:0]  s0_2_r, s1_2_r;
  logic [NBLK-1:0]             k0_2_r, k1_2_r;
  logic                        c0_2_r, amsb_2_r, bxmsb_2_r;
  logic [WIDTH-1:0]            sum_s;
  logic                        cout_s, ovf_s;
  logic [WIDTH-1:0]            sum_r;
  logic                        cout_r, ovf_r;

  assign stall_s       = v3_r && !bus.out_ready;
  assign adv_s         = !stall_s;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v3_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    assign blk0_s[k] = {1'b0, a1_r[k*BLOCK +: BLOCK]} + {1'b0, bx1_r[k*BLOCK +: BLOCK]};
    assign blk1_s[k] = blk0_s[k] + {{BLOCK{1'b0}}, 1'b1};
  end

  // Carry-select chain: the real carry ripples through the muxes, not through adders.
  always_comb begin
    logic c_v;
    c_v   = c0_2_r;
    sum_s = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (c_v) begin
        sum_s[k*BLOCK +: BLOCK] = s1_2_r[k];
        c_v                     = k1_2_r[k];
      end else begin
        sum_s[k*BLOCK +: BLOCK] = s0_2_r[k];
        c_v                     = k0_2_r[k];
      end
    end
    cout_s = c_v;
    ovf_s  = (amsb_2_r == bxmsb_2_r) && (sum_s[WIDTH-1] != amsb_2_r);
  end

  // Stage 1: capture operands, folding subtraction into inverted b and inverted borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      a1_r  <= '0;
      bx1_r <= '0;
      c01_r <= 1'b0;
    end else if (adv_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        a1_r  <= bus.a;
        bx1_r <= bus.sub ? ~bus.b : bus.b;
        c01_r <= bus.sub ? ~bus.cin : bus.cin;
      end
    end
  end

  // Stage 2: register both carry-in hypotheses of every block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r      <= 1'b0;
      s0_2_r    <= '0;
      s1_2_r    <= '0;
      k0_2_r    <= '0;
      k1_2_r    <= '0;
      c0_2_r    <= 1'b0;
      amsb_2_r  <= 1'b0;
      bxmsb_2_r <= 1'b0;
    end else if (adv_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        for (int k = 0; k < NBLK; k++) begin
          s0_2_r[k] <= blk0_s[k][BLOCK-1:0];
          k0_2_r[k] <= blk0_s[k][BLOCK];
          s1_2_r[k] <= blk1_s[k][BLOCK-1:0];
          k1_2_r[k] <= blk1_s[k][BLOCK];
        end
        c0_2_r    <= c01_r;
        amsb_2_r  <= a1_r[WIDTH-1];
        bxmsb_2_r <= bx1_r[WIDTH-1];
      end
    end
  end

  // Stage 3: register the selected result, carry-out and signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r   <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (adv_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        sum_r  <= sum_s;
        cout_r <= cout_s;
        ovf_r  <= ovf_s;
      end
    end
  end
endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Scoreboard bench: expected results are pushed at accept from an arithmetic reference model,
// and an independent monitor pops and compares at every consume.
module tb_csa_pipe_addsub;
  localparam int W = 16;
  localparam int B = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_pipe_addsub_if #(.WIDTH(W)) vif ();
  csa_pipe_addsub #(.WIDTH(W), .BLOCK(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  exp_t q[$];
  exp_t e_pop;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;
  int   pops = 0;
  int   pops0;
  logic prev_ov = 1'b0;
  logic prev_cons = 1'b0;
  bit   pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint m, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - m : ua;
    sb = b[W-1] ? ub - m : ub;
    if (!sub) begin
      r      = ua + ub + longint'(cin);
      sr     = sa + sb + longint'(cin);
      e.cout = (r >= m);
    end else begin
      r      = ua - ub - longint'(cin);
      sr     = sa - sb - longint'(cin);
      e.cout = (r >= 0);
    end
    e.sum = r[W-1:0];
    e.ovf = (sr > (m / 2) - 1) || (sr < -(m / 2));
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    logic acc;
    int   guard;
    vif.a = a; vif.b = b; vif.cin = cin; vif.sub = sub;
    vif.in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = vif.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    vif.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want 1", guard);
    end
  endtask

  task automatic drain(input int budget);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < budget) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // out_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = random.
  always @(posedge clk) begin
    #1;
    case (mode)
      1:       vif.out_ready = ~vif.out_ready;
      2:       vif.out_ready = ($urandom_range(0, 3) != 0);
      default: vif.out_ready = 1'b1;
    endcase
  end

  // Scoreboard push: the beat presented now is taken at the coming edge.
  always @(negedge clk) begin
    if (rst_n && vif.in_valid && vif.in_ready) q.push_back(model(vif.a, vif.b, vif.cin, vif.sub));
  end

  // Monitor: handshake rules and in-order result comparison.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      prev_cons = 1'b0;
    end else begin
      chk("in_ready", 64'(vif.in_ready), 64'(!(vif.out_valid && !vif.out_ready)));
      if (prev_ov && !prev_cons) chk("out_valid_hold", 64'(vif.out_valid), 64'd1);
      if (vif.out_valid && vif.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got sum 0x%0h, want no result", vif.sum);
        end else begin
          e_pop = q.pop_front();
          pops++;
          chk("result", 64'({vif.sum, vif.cout, vif.ovf}), 64'(e_pop));
        end
      end
      prev_ov   = vif.out_valid;
      prev_cons = vif.out_valid && vif.out_ready;
    end
  end

  initial begin
    vif.in_valid = 1'b0; vif.a = '0; vif.b = '0; vif.cin = 1'b0; vif.sub = 1'b0;
    vif.out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 64'(vif.out_valid), 64'd0);
    chk("rst_sum", 64'(vif.sum), 64'd0);
    chk("rst_cout", 64'(vif.cout), 64'd0);
    chk("rst_ovf", 64'(vif.ovf), 64'd0);
    chk("rst_in_ready", 64'(vif.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0005, 16'h0003, 1'b1, 1'b1);
    drain(50);

    mode  = 1;
    pops0 = pops;
    for (int i = 0; i < 8; i++) send_rand();
    drain(100);
    mode = 0;
    chk("bp_result_count", 64'(pops - pops0), 64'd8);

    for (int i = 0; i < 10; i++) begin
      vif.in_valid = (i < 6) ? pat[i] : 1'b0;
      vif.a = W'($urandom); vif.b = W'($urandom);
      vif.cin = 1'($urandom); vif.sub = 1'($urandom);
      @(negedge clk);
      chk("bubble_out_valid", 64'(vif.out_valid), 64'((i >= 3 && i < 9) ? pat[i-3] : 1'b0));
      @(posedge clk);
      #1;
    end
    vif.in_valid = 1'b0;
    drain(50);

    for (int i = 0; i < 3; i++) send_rand();
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 64'(vif.out_valid), 64'd0);
    chk("midrst_sum", 64'(vif.sum), 64'd0);
    chk("midrst_in_ready", 64'(vif.in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(vif.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    drain(1000);
    mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
